// File: rtl/gem_offset_lut_ctrl.sv
// GEM-CSC slope-offset lookup tables: 8 banks x 16 entries, dual-CLCT 2-stage lookup, init and VME write sequencing.
// Define GEM_OFFSET_READBACK_EN to add the VME single-entry readback port and READ state.
module gem_offset_lut_ctrl #(
  parameter int unsigned       MXADRB     = 4,
  parameter int unsigned       MXDATB     = 8,
  parameter logic [MXDATB-1:0] INIT_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clct0_vld,
  input  logic [MXADRB-1:0]   clct0_bend,
  input  logic                isME1a0,
  input  logic                clct1_vld,
  input  logic [MXADRB-1:0]   clct1_bend,
  input  logic                isME1a1,
  input  logic                even,
  output logic [MXDATB-1:0]   clct0_gemA_offset,
  output logic [MXDATB-1:0]   clct0_gemB_offset,
  output logic [MXDATB-1:0]   clct1_gemA_offset,
  output logic [MXDATB-1:0]   clct1_gemB_offset,
  output logic                clct0_offset_vld,
  output logic                clct1_offset_vld,
  input  logic                wr_req,
  input  logic [MXADRB+2:0]   wr_adr,
  input  logic [MXDATB-1:0]   wr_data,
  output logic                wr_ack,
  input  logic                init_req,
  output logic                lut_ready
`ifdef GEM_OFFSET_READBACK_EN
  ,
  input  logic                rd_req,
  input  logic [MXADRB+2:0]   rd_adr,
  output logic [MXDATB-1:0]   rd_data,
  output logic                rd_ack
`endif
);

  localparam int unsigned ADRW  = MXADRB + 3;
  localparam int unsigned DEPTH = 2 ** ADRW;

`ifdef GEM_OFFSET_READBACK_EN
  typedef enum logic [2:0] {INIT, IDLE, WRITE, WAIT_REL, READ} stateT;
`else
  typedef enum logic [1:0] {INIT, IDLE, WRITE, WAIT_REL} stateT;
`endif

  stateT             state;
  logic [ADRW-1:0]   initCnt;
  logic [ADRW-1:0]   wrAdrQ;
  logic [MXDATB-1:0] wrDataQ;

  logic [MXDATB-1:0] lut [DEPTH];

  logic              memWe;
  logic [ADRW-1:0]   memWa;
  logic [MXDATB-1:0] memWd;
  logic              relBusy_c;

  logic              s1Vld0;
  logic              s1Vld1;
  logic [MXADRB-1:0] s1Bend0;
  logic [MXADRB-1:0] s1Bend1;
  logic              s1Me1a0;
  logic              s1Me1a1;
  logic              s1Even;

  // A completed handshake is released only once every requester has dropped.
`ifdef GEM_OFFSET_READBACK_EN
  assign relBusy_c = wr_req | rd_req;
`else
  assign relBusy_c = wr_req;
`endif

  // Sequencer: table initialisation, write/read handshakes, ready flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      initCnt   <= '0;
      lut_ready <= 1'b0;
      wr_ack    <= 1'b0;
      wrAdrQ    <= '0;
      wrDataQ   <= '0;
`ifdef GEM_OFFSET_READBACK_EN
      rd_ack    <= 1'b0;
      rd_data   <= '0;
`endif
    end else begin
      wr_ack <= 1'b0;
`ifdef GEM_OFFSET_READBACK_EN
      rd_ack <= 1'b0;
`endif
      if (state == INIT) begin
        lut_ready <= 1'b0;
        initCnt   <= init_req ? '0 : initCnt + ADRW'(1);
        if (!init_req && (initCnt == ADRW'(DEPTH - 1))) begin
          state <= IDLE;
        end
      end else if (init_req) begin
        // A write in progress still lands this cycle; its ack is already out.
        state     <= INIT;
        initCnt   <= '0;
        lut_ready <= 1'b0;
      end else begin
        lut_ready <= 1'b1;
        case (state)
          IDLE: begin
            if (wr_req) begin
              wrAdrQ  <= wr_adr;
              wrDataQ <= wr_data;
              wr_ack  <= 1'b1;
              state   <= WRITE;
            end
`ifdef GEM_OFFSET_READBACK_EN
            else if (rd_req) begin
              rd_data <= lut[rd_adr];
              rd_ack  <= 1'b1;
              state   <= READ;
            end
`endif
          end
          WRITE:    state <= WAIT_REL;
`ifdef GEM_OFFSET_READBACK_EN
          READ:     state <= WAIT_REL;
`endif
          WAIT_REL: begin
            if (!relBusy_c) begin
              state <= IDLE;
            end
          end
          default:  state <= INIT;
        endcase
      end
    end
  end

  // Single table write port, shared by the init sweep and VME writes.
  always_comb begin
    memWe = 1'b0;
    memWa = initCnt;
    memWd = INIT_VALUE;
    if (state == INIT) begin
      memWe = 1'b1;
    end else if (state == WRITE) begin
      memWe = 1'b1;
      memWa = wrAdrQ;
      memWd = wrDataQ;
    end
  end

  // Storage has no reset; contents become defined once the init sweep completes.
  always_ff @(posedge clock) begin
    if (memWe) begin
      lut[memWa] <= memWd;
    end
  end

  // Two-stage lookup; a same-cycle write to the read entry returns the old data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1Vld0            <= 1'b0;
      s1Vld1            <= 1'b0;
      s1Bend0           <= '0;
      s1Bend1           <= '0;
      s1Me1a0           <= 1'b0;
      s1Me1a1           <= 1'b0;
      s1Even            <= 1'b0;
      clct0_offset_vld  <= 1'b0;
      clct1_offset_vld  <= 1'b0;
      clct0_gemA_offset <= '0;
      clct0_gemB_offset <= '0;
      clct1_gemA_offset <= '0;
      clct1_gemB_offset <= '0;
    end else begin
      s1Vld0  <= clct0_vld & lut_ready;
      s1Vld1  <= clct1_vld & lut_ready;
      s1Bend0 <= clct0_bend;
      s1Bend1 <= clct1_bend;
      s1Me1a0 <= isME1a0;
      s1Me1a1 <= isME1a1;
      s1Even  <= even;

      clct0_offset_vld  <= s1Vld0;
      clct1_offset_vld  <= s1Vld1;
      clct0_gemA_offset <= s1Vld0 ? lut[{s1Me1a0, s1Even, 1'b0, s1Bend0}] : '0;
      clct0_gemB_offset <= s1Vld0 ? lut[{s1Me1a0, s1Even, 1'b1, s1Bend0}] : '0;
      clct1_gemA_offset <= s1Vld1 ? lut[{s1Me1a1, s1Even, 1'b0, s1Bend1}] : '0;
      clct1_gemB_offset <= s1Vld1 ? lut[{s1Me1a1, s1Even, 1'b1, s1Bend1}] : '0;
    end
  end

endmodule

// File: tb/tb_gem_offset_lut_ctrl.sv
// Bench for gem_offset_lut_ctrl: timeline model of table contents/handshake, per-cycle compare, directed vectors.
module tb_gem_offset_lut_ctrl;

  localparam logic [7:0] INIT_V = 8'h00;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       clct0_vld = 0, clct1_vld = 0, isME1a0 = 0, isME1a1 = 0, even = 0;
  logic [3:0] clct0_bend = '0, clct1_bend = '0;
  logic       wr_req = 0, init_req = 0;
  logic [6:0] wr_adr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] clct0_gemA_offset, clct0_gemB_offset, clct1_gemA_offset, clct1_gemB_offset;
  logic       clct0_offset_vld, clct1_offset_vld, wr_ack, lut_ready;
`ifdef GEM_OFFSET_READBACK_EN
  logic       rd_req = 0;
  logic [6:0] rd_adr = '0;
  logic [7:0] rd_data;
  logic       rd_ack;
`endif

  gem_offset_lut_ctrl #(.INIT_VALUE(INIT_V)) dut (
    .clock(clk), .reset_n(rst_n),
    .clct0_vld(clct0_vld), .clct0_bend(clct0_bend), .isME1a0(isME1a0),
    .clct1_vld(clct1_vld), .clct1_bend(clct1_bend), .isME1a1(isME1a1),
    .even(even),
    .clct0_gemA_offset(clct0_gemA_offset), .clct0_gemB_offset(clct0_gemB_offset),
    .clct1_gemA_offset(clct1_gemA_offset), .clct1_gemB_offset(clct1_gemB_offset),
    .clct0_offset_vld(clct0_offset_vld), .clct1_offset_vld(clct1_offset_vld),
    .wr_req(wr_req), .wr_adr(wr_adr), .wr_data(wr_data), .wr_ack(wr_ack),
    .init_req(init_req), .lut_ready(lut_ready)
`ifdef GEM_OFFSET_READBACK_EN
    , .rd_req(rd_req), .rd_adr(rd_adr), .rd_data(rd_data), .rd_ack(rd_ack)
`endif
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: table contents, the edge a write lands, the last init edge, and the lookup pipe.
  logic [7:0] mMem [128];
  int         mEdge = 0, mInitEnd = 0, mWrEdge = -1;
  logic [6:0] mWrAdr;
  logic [7:0] mWrData;
  logic       mFresh, mReady, mRel, eAck;
  logic       pV [2], pMe [2], pEv [2], eV [2];
  logic [3:0] pBend [2];
  logic [7:0] eA [2], eB [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mFresh = 1; mReady = 0; mRel = 0; mWrEdge = -1; eAck = 0;
      for (int c = 0; c < 2; c++) begin
        pV[c] = 0; eV[c] = 0; eA[c] = 8'h00; eB[c] = 8'h00;
      end
    end else begin
      if (mFresh) begin
        mInitEnd = mEdge + 127;
        mFresh = 0;
      end
      for (int c = 0; c < 2; c++) begin
        eV[c] = pV[c];
        eA[c] = pV[c] ? mMem[{pMe[c], pEv[c], 1'b0, pBend[c]}] : 8'h00;
        eB[c] = pV[c] ? mMem[{pMe[c], pEv[c], 1'b1, pBend[c]}] : 8'h00;
      end
      pV[0] = clct0_vld & mReady; pMe[0] = isME1a0; pEv[0] = even; pBend[0] = clct0_bend;
      pV[1] = clct1_vld & mReady; pMe[1] = isME1a1; pEv[1] = even; pBend[1] = clct1_bend;
      eAck = 0;
      if (mEdge <= mInitEnd) begin
        mReady = 0;
        if (init_req) mInitEnd = mEdge + 128;
        else if (mEdge == mInitEnd) for (int i = 0; i < 128; i++) mMem[i] = INIT_V;
      end else if (mEdge == mWrEdge) begin
        mMem[mWrAdr] = mWrData;
        if (init_req) begin
          mInitEnd = mEdge + 128; mReady = 0;
        end else mRel = 1;
      end else if (init_req) begin
        mInitEnd = mEdge + 128; mReady = 0; mRel = 0;
      end else begin
        mReady = 1;
        if (mRel) begin
          if (!wr_req) mRel = 0;
        end else if (wr_req) begin
          mWrEdge = mEdge + 1; mWrAdr = wr_adr; mWrData = wr_data; eAck = 1;
        end
      end
      mEdge++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_ctl", {lut_ready, wr_ack, clct0_offset_vld, clct1_offset_vld}, 64'd0);
      check("reset_ofs", {clct0_gemA_offset, clct0_gemB_offset, clct1_gemA_offset, clct1_gemB_offset}, 64'd0);
    end else begin
      check("lut_ready", lut_ready, mReady);
      check("wr_ack", wr_ack, eAck);
      check("clct0", {clct0_offset_vld, clct0_gemA_offset, clct0_gemB_offset}, {eV[0], eA[0], eB[0]});
      check("clct1", {clct1_offset_vld, clct1_gemA_offset, clct1_gemB_offset}, {eV[1], eA[1], eB[1]});
    end
  end

  task automatic doWrite(input logic [6:0] a, input logic [7:0] d);
    wr_req = 1; wr_adr = a; wr_data = d;
    @(negedge clk); check("wr_ack_pulse", wr_ack, 1);
    wr_req = 0;
    @(negedge clk); check("wr_ack_clear", wr_ack, 0);
    @(negedge clk);
  endtask

  int nAck;

  initial begin
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Lookup before the table is ready.
    clct0_vld = 1; clct0_bend = 4'd5; isME1a0 = 1;
    repeat (3) @(negedge clk);
    check("early_lookup", {clct0_offset_vld, clct0_gemA_offset, clct0_gemB_offset}, 64'd0);
    clct0_vld = 0;
    repeat (125) @(negedge clk);
    check("ready_edge127", lut_ready, 0);
    @(negedge clk);
    check("ready_edge128", lut_ready, 1);

    // Write ME1a/odd/layerB/bend3, then look it up from both CLCTs.
    doWrite(7'b1010011, 8'hF6);
    clct1_vld = 1; clct1_bend = 4'd3; isME1a1 = 1;
    clct0_vld = 1; clct0_bend = 4'd3; isME1a0 = 1; even = 0;
    @(negedge clk);
    clct0_vld = 0; clct1_vld = 0;
    @(negedge clk);
    check("c1_gemB_F6", {clct1_offset_vld, clct1_gemB_offset}, {1'b1, 8'hF6});
    check("c1_gemA_00", clct1_gemA_offset, 8'h00);
    check("c0_same_entry", clct0_gemB_offset, 8'hF6);

    // Held request: one ack only.
    wr_req = 1; wr_adr = 7'h15; wr_data = 8'h3C; nAck = 0;
    @(negedge clk);
    check("hold_first_ack", wr_ack, 1);
    if (wr_ack) nAck++;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (wr_ack) nAck++;
    end
    wr_req = 0;
    check("hold_single_ack", nAck, 1);
    @(negedge clk);
    doWrite(7'h16, 8'h81);

    // Write/read collision on entry 0x23 (non-ME1a, even, layerA, bend3).
    wr_req = 1; wr_adr = 7'h23; wr_data = 8'h05;
    clct0_vld = 1; clct0_bend = 4'd3; isME1a0 = 0; even = 1;
    @(negedge clk);
    wr_req = 0;
    @(negedge clk);
    check("collide_old", {clct0_offset_vld, clct0_gemA_offset}, {1'b1, 8'h00});
    clct0_vld = 0;
    @(negedge clk);
    check("collide_new", {clct0_offset_vld, clct0_gemA_offset}, {1'b1, 8'h05});
    @(negedge clk);

    // init_req during WRITE; writes during INIT must not be acked.
    wr_req = 1; wr_adr = 7'h40; wr_data = 8'h7E;
    @(negedge clk);
    check("init_wr_ack", wr_ack, 1);
    init_req = 1; wr_req = 0;
    @(negedge clk);
    init_req = 0;
    check("init_ready_drop", lut_ready, 0);
    wr_req = 1; wr_adr = 7'h01; wr_data = 8'hAA; nAck = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ack) nAck++;
    end
    wr_req = 0;
    check("init_no_ack", nAck, 0);
    repeat (108) @(negedge clk);
    check("reinit_not_yet", lut_ready, 0);
    @(negedge clk);
    check("reinit_ready", lut_ready, 1);
    clct0_vld = 1; clct0_bend = 4'd0; isME1a0 = 1;
    clct1_vld = 1; clct1_bend = 4'd3; isME1a1 = 1; even = 0;
    @(negedge clk);
    clct0_vld = 0; clct1_vld = 0;
    @(negedge clk);
    check("reinit_0x40", clct0_gemA_offset, 8'h00);
    check("reinit_0x53", clct1_gemB_offset, 8'h00);

    // Reset in the middle of an init sweep (counter at 60).
    init_req = 1;
    @(negedge clk);
    init_req = 0;
    repeat (60) @(negedge clk);
    #2 rst_n = 0;
    #1 check("async_reset", {lut_ready, wr_ack, clct0_offset_vld, clct1_offset_vld,
                             clct0_gemA_offset, clct1_gemB_offset}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (128) @(negedge clk);
    check("rst_init_not_yet", lut_ready, 0);
    @(negedge clk);
    check("rst_init_ready", lut_ready, 1);
    clct0_vld = 1; clct0_bend = 4'd3; isME1a0 = 0; even = 1;
    clct1_vld = 1; clct1_bend = 4'd6; isME1a1 = 0;
    @(negedge clk);
    clct0_vld = 0; clct1_vld = 0;
    @(negedge clk);
    check("rst_0x23_init", clct0_gemA_offset, 8'h00);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
